// File: rtl/miss_tracker_pkg.sv
// Shared types and helpers for the outstanding-miss tracker.
// The entry struct widths come from the localparams below; the tracker's
// default parameters are tied to them so the two stay consistent.
package miss_tracker_pkg;

  localparam int MT_NUM_ENTRIES = 4;
  localparam int MT_ADDR_WIDTH  = 26;
  localparam int MT_THREADS     = 4;
  localparam int MT_INDEX_WIDTH = $clog2(MT_NUM_ENTRIES);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2
  } miss_entry_state_t;

  typedef struct packed {
    miss_entry_state_t       state;
    logic [MT_ADDR_WIDTH-1:0] addr;
    logic [MT_THREADS-1:0]    waiting;
  } miss_entry_t;

  localparam miss_entry_t MT_ENTRY_FREE = '{state: FREE, addr: '0, waiting: '0};

  // Keep only the lowest set bit of a slot vector.
  function automatic logic [MT_NUM_ENTRIES-1:0] isolate_lowest(
    input logic [MT_NUM_ENTRIES-1:0] v
  );
    return v & (~v + MT_NUM_ENTRIES'(1));
  endfunction

  // One-hot slot vector to binary slot index (zero when empty).
  function automatic logic [MT_INDEX_WIDTH-1:0] oh_to_idx(
    input logic [MT_NUM_ENTRIES-1:0] oh
  );
    logic [MT_INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < MT_NUM_ENTRIES; i++) begin
      if (oh[i]) idx = idx | MT_INDEX_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/miss_tracker.sv
// Outstanding cache-line miss tracker. Owns the CAM update port, merges
// repeat misses into pending slots, issues one memory request at a time
// and wakes the waiting threads when a fill returns.
module miss_tracker
  import miss_tracker_pkg::*;
#(
  parameter int NUM_ENTRIES = MT_NUM_ENTRIES,
  parameter int ADDR_WIDTH  = MT_ADDR_WIDTH,
  parameter int THREADS     = MT_THREADS,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES),
  parameter int TID_WIDTH   = $clog2(THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_en,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  input  logic [TID_WIDTH-1:0]   miss_thread_idx,
  output logic                   miss_stall,
  output logic [ADDR_WIDTH-1:0]  cam_lookup_key,
  input  logic                   cam_lookup_hit,
  input  logic [INDEX_WIDTH-1:0] cam_lookup_idx,
  output logic                   cam_update_en,
  output logic [ADDR_WIDTH-1:0]  cam_update_key,
  output logic [INDEX_WIDTH-1:0] cam_update_idx,
  output logic                   cam_update_valid,
  output logic                   mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [INDEX_WIDTH-1:0] mem_req_idx,
  input  logic                   mem_req_ready,
  input  logic                   fill_en,
  input  logic [INDEX_WIDTH-1:0] fill_idx,
  output logic                   wake_en,
  output logic [THREADS-1:0]     wake_bitmap
);

  miss_entry_t              entries_q [NUM_ENTRIES];
  miss_entry_t              entries_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   free_vec;
  logic [NUM_ENTRIES-1:0]   pend_nxt_vec;
  logic [INDEX_WIDTH-1:0]   alloc_idx;
  logic [INDEX_WIDTH-1:0]   next_req_idx;
  logic [THREADS-1:0]       thread_bit;
  logic                     fill_ok;
  logic                     hit_fill;
  logic                     merge;
  logic                     any_free;
  logic                     alloc;

  assign cam_lookup_key = miss_addr;

  // Classify this cycle's miss/fill and build the next slot table.
  // A fill to a non-ISSUED slot is ignored (fill_ok stays low), but a raw
  // fill_en still blocks allocation because the fill owns the CAM port.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i] = (entries_q[i].state == FREE);
    end
    thread_bit = THREADS'(1) << miss_thread_idx;
    fill_ok    = fill_en && (entries_q[fill_idx].state == ISSUED);
    hit_fill   = miss_en && cam_lookup_hit && fill_ok && (cam_lookup_idx == fill_idx);
    merge      = miss_en && cam_lookup_hit && !hit_fill;
    any_free   = |free_vec;
    alloc_idx  = oh_to_idx(isolate_lowest(free_vec));
    alloc      = miss_en && !cam_lookup_hit && any_free && !fill_en;
    miss_stall = miss_en && !cam_lookup_hit && (!any_free || fill_en);

    entries_d = entries_q;
    if (mem_req_valid && mem_req_ready) entries_d[mem_req_idx].state = ISSUED;
    if (merge) begin
      entries_d[cam_lookup_idx].waiting = entries_q[cam_lookup_idx].waiting | thread_bit;
    end
    if (alloc) begin
      entries_d[alloc_idx] = '{state: PENDING, addr: miss_addr, waiting: thread_bit};
    end
    if (fill_ok) entries_d[fill_idx] = MT_ENTRY_FREE;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      pend_nxt_vec[i] = (entries_d[i].state == PENDING);
    end
    next_req_idx = oh_to_idx(isolate_lowest(pend_nxt_vec));
  end

  // Single CAM write port: fill invalidate wins over allocation install.
  always_comb begin
    cam_update_en    = 1'b0;
    cam_update_valid = 1'b0;
    cam_update_idx   = '0;
    cam_update_key   = '0;
    if (!reset) begin
      if (fill_ok) begin
        cam_update_en  = 1'b1;
        cam_update_idx = fill_idx;
        cam_update_key = entries_q[fill_idx].addr;
      end else if (alloc) begin
        cam_update_en    = 1'b1;
        cam_update_valid = 1'b1;
        cam_update_idx   = alloc_idx;
        cam_update_key   = miss_addr;
      end
    end
  end

  // Slot table register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= MT_ENTRY_FREE;
    end else begin
      entries_q <= entries_d;
    end
  end

  // Memory request register: present the lowest PENDING slot of the next
  // table (so an allocation shows up one cycle later), hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_idx   <= '0;
    end else if (!mem_req_valid || mem_req_ready) begin
      mem_req_valid <= |pend_nxt_vec;
      mem_req_addr  <= entries_d[next_req_idx].addr;
      mem_req_idx   <= next_req_idx;
    end
  end

  // Wake pulse one cycle after a fill, including a thread that hit the
  // slot in the same cycle it was being filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      wake_en     <= 1'b0;
      wake_bitmap <= '0;
    end else begin
      wake_en     <= fill_ok;
      wake_bitmap <= fill_ok ? (entries_q[fill_idx].waiting | (hit_fill ? thread_bit : '0)) : '0;
    end
  end

  // Protocol sanity checks, simulation only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!fill_en || fill_ok)
        else $fatal(1, "miss_tracker: fill to slot %0d that is not ISSUED", fill_idx);
      assert (!merge || ((entries_q[cam_lookup_idx].waiting & thread_bit) == '0))
        else $fatal(1, "miss_tracker: thread %0d merged twice into slot %0d",
                    miss_thread_idx, cam_lookup_idx);
    end
  end

endmodule

// File: tb/tb_miss_tracker.sv
// Testbench for miss_tracker: directed scenarios followed by random traffic,
// all checked against a slot-level reference model. A small CAM lives here,
// driven by the tracker's update port, as the parent would provide.
module tb_miss_tracker;
  import miss_tracker_pkg::*;

  localparam int NE = 4;
  localparam int AW = 26;
  localparam int TH = 4;
  localparam int IW = 2;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_en;
  logic [AW-1:0] miss_addr;
  logic [TW-1:0] miss_thread_idx;
  logic          miss_stall;
  logic [AW-1:0] cam_lookup_key;
  logic          cam_lookup_hit;
  logic [IW-1:0] cam_lookup_idx;
  logic          cam_update_en;
  logic [AW-1:0] cam_update_key;
  logic [IW-1:0] cam_update_idx;
  logic          cam_update_valid;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [IW-1:0] mem_req_idx;
  logic          mem_req_ready;
  logic          fill_en;
  logic [IW-1:0] fill_idx;
  logic          wake_en;
  logic [TH-1:0] wake_bitmap;

  always #5 clk = ~clk;

  miss_tracker #(.NUM_ENTRIES(NE), .ADDR_WIDTH(AW), .THREADS(TH)) dut (
    .clk(clk), .reset(reset), .miss_en(miss_en), .miss_addr(miss_addr),
    .miss_thread_idx(miss_thread_idx), .miss_stall(miss_stall),
    .cam_lookup_key(cam_lookup_key), .cam_lookup_hit(cam_lookup_hit),
    .cam_lookup_idx(cam_lookup_idx), .cam_update_en(cam_update_en),
    .cam_update_key(cam_update_key), .cam_update_idx(cam_update_idx),
    .cam_update_valid(cam_update_valid), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_idx(mem_req_idx),
    .mem_req_ready(mem_req_ready), .fill_en(fill_en), .fill_idx(fill_idx),
    .wake_en(wake_en), .wake_bitmap(wake_bitmap)
  );

  // Environment CAM
  logic [AW-1:0] cam_key [NE];
  logic [NE-1:0] cam_v;

  always @(posedge clk) begin
    if (reset) cam_v <= '0;
    else if (cam_update_en) begin
      cam_v[cam_update_idx]   <= cam_update_valid;
      cam_key[cam_update_idx] <= cam_update_key;
    end
  end

  always_comb begin
    cam_lookup_hit = 1'b0;
    cam_lookup_idx = '0;
    for (int i = 0; i < NE; i++) begin
      if (cam_v[i] && cam_key[i] == cam_lookup_key) begin
        cam_lookup_hit = 1'b1;
        cam_lookup_idx = IW'(i);
      end
    end
  end

  // Reference model: 0 = free, 1 = waiting for request, 2 = request accepted
  int            m_state [NE];
  logic [AW-1:0] m_addr  [NE];
  logic [TH-1:0] m_wait  [NE];
  bit            m_req_v;
  int            m_req_idx;
  bit            m_wake_en;
  logic [TH-1:0] m_wake_bm;
  bit   [TH-1:0] tblk;

  int n_vec = 0;
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NE; i++) begin
      m_state[i] = 0;
      m_wait[i]  = '0;
      m_addr[i]  = '0;
    end
    m_req_v   = 1'b0;
    m_req_idx = 0;
    m_wake_en = 1'b0;
    m_wake_bm = '0;
    tblk      = '0;
  endtask

  // Hold reset for two cycles with a miss driven, checking reset outputs.
  task automatic reset_dut();
    reset = 1'b1;
    miss_en = 1'b1; miss_addr = AW'(32'h3ff); miss_thread_idx = '0;
    fill_en = 1'b0; fill_idx = '0; mem_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_wake_en", wake_en, 0);
    chk("rst_wake_bitmap", wake_bitmap, 0);
    chk("rst_cam_update_en", cam_update_en, 0);
    chk("rst_cam_update_valid", cam_update_valid, 0);
    reset = 1'b0;
    miss_en = 1'b0;
    model_clear();
  endtask

  // One clock cycle of stimulus, checked against the model.
  task automatic step(input bit me, input logic [AW-1:0] ma, input int tid,
                      input bit fe, input int fi, input bit rdy);
    bit hit, same, merge, anyfree, alloc, fill_ok;
    int h, f;
    logic [TH-1:0] tb;
    miss_en = me; miss_addr = ma; miss_thread_idx = TW'(tid);
    fill_en = fe; fill_idx = IW'(fi); mem_req_ready = rdy;
    #3;
    hit = 1'b0; h = 0;
    for (int i = 0; i < NE; i++) if (m_state[i] != 0 && m_addr[i] == ma) begin hit = 1'b1; h = i; end
    f = -1;
    for (int i = NE - 1; i >= 0; i--) if (m_state[i] == 0) f = i;
    anyfree = (f >= 0);
    fill_ok = fe && m_state[fi] == 2;
    same    = me && hit && fill_ok && h == fi;
    merge   = me && hit && !same;
    alloc   = me && !hit && anyfree && !fe;
    tb      = TH'(1) << tid;
    chk("miss_stall", miss_stall, me && !hit && (!anyfree || fe));
    chk("cam_lookup_key", cam_lookup_key, ma);
    chk("cam_update_en", cam_update_en, fill_ok || alloc);
    if (fill_ok || alloc) begin
      chk("cam_update_valid", cam_update_valid, !fill_ok);
      chk("cam_update_idx", cam_update_idx, fill_ok ? fi : f);
    end
    if (alloc) chk("cam_update_key", cam_update_key, ma);

    if (m_req_v && rdy) m_state[m_req_idx] = 2;
    if (merge) begin m_wait[h] = m_wait[h] | tb; tblk[tid] = 1'b1; end
    if (alloc) begin m_state[f] = 1; m_addr[f] = ma; m_wait[f] = tb; tblk[tid] = 1'b1; end
    m_wake_en = fill_ok;
    if (fill_ok) begin
      m_wake_bm  = m_wait[fi] | (same ? tb : '0);
      m_state[fi] = 0;
      m_wait[fi]  = '0;
    end
    if (!m_req_v || rdy) begin
      m_req_v = 1'b0;
      for (int i = NE - 1; i >= 0; i--) if (m_state[i] == 1) begin m_req_v = 1'b1; m_req_idx = i; end
    end

    @(posedge clk);
    #1;
    n_vec++;
    chk("wake_en", wake_en, m_wake_en);
    if (m_wake_en) begin
      chk("wake_bitmap", wake_bitmap, m_wake_bm);
      tblk = tblk & ~m_wake_bm;
    end
    chk("mem_req_valid", mem_req_valid, m_req_v);
    if (m_req_v) begin
      chk("mem_req_idx", mem_req_idx, m_req_idx);
      chk("mem_req_addr", mem_req_addr, m_addr[m_req_idx]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, fi, s;
    bit me, fe, rdy;
    logic [AW-1:0] a;

    model_clear();
    @(negedge clk);
    reset_dut();

    // First miss allocates slot 0 and requests memory the next cycle
    step(1, 26'h100, 0, 0, 0, 0);
    chk("plan1_req_addr", mem_req_addr, 32'h100);
    chk("plan1_req_idx", mem_req_idx, 0);
    step(0, 26'h0, 0, 0, 0, 1);
    // Merge while ISSUED, then fill wakes threads 0 and 2
    step(1, 26'h100, 2, 0, 0, 0);
    step(0, 26'h0, 0, 1, 0, 0);
    chk("plan2_wake_bitmap", wake_bitmap, 4'b0101);

    // Fill all four slots, fifth miss stalls
    for (int i = 0; i < NE; i++) step(1, AW'(32'h10 + i), i, 0, 0, 0);
    step(1, 26'h14, 0, 0, 0, 0);
    for (int i = 0; i < NE; i++) step(1, 26'h14, 0, 0, 0, 1);
    step(1, 26'h14, 0, 1, 1, 0);
    step(1, 26'h14, 0, 0, 0, 0);
    // Fill with a free slot available still stalls a new miss
    step(0, 26'h0, 0, 1, 2, 0);
    step(1, 26'h20, 1, 1, 3, 0);
    step(1, 26'h20, 1, 0, 0, 0);
    // Same-cycle fill and hit on slot 0
    step(1, 26'h10, 3, 1, 0, 0);
    chk("plan5_wake_bitmap", wake_bitmap, 4'b1001);
    step(1, 26'h10, 3, 0, 0, 0);

    // Request held stable under backpressure
    reset_dut();
    step(1, 26'ha0, 0, 0, 0, 0);
    step(1, 26'ha1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 26'h0, 0, 0, 0, 0);
      chk("plan6_hold_idx", mem_req_idx, 0);
      chk("plan6_hold_addr", mem_req_addr, 32'ha0);
    end
    step(0, 26'h0, 0, 0, 0, 1);
    chk("plan6_next_idx", mem_req_idx, 1);
    chk("plan6_next_addr", mem_req_addr, 32'ha1);

    // Random traffic from threads that are not waiting on a fill
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      t  = $urandom_range(0, TH - 1);
      me = !tblk[t] && ($urandom_range(0, 3) != 0);
      a  = AW'(32'h40 + $urandom_range(0, 5));
      fi = -1;
      s  = $urandom_range(0, NE - 1);
      for (int k = 0; k < NE; k++) if (m_state[(s + k) % NE] == 2) fi = (s + k) % NE;
      fe  = (fi >= 0) && ($urandom_range(0, 2) == 0);
      rdy = $urandom_range(0, 1) != 0;
      step(me, a, t, fe, fe ? fi : 0, rdy);
    end

    // Reset with slots in flight discards them without a wake
    step(1, 26'h77, 0, 0, 0, 0);
    reset_dut();
    step(0, 26'h0, 0, 0, 0, 0);
    step(1, 26'h77, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
